// File: rtl/reglist_encoder_pkg.sv
// Shared types and helpers for the register-list encoder.
// State encoding, fixed widths and the list popcount.
package reglist_encoder_pkg;

  localparam int LIST_W = 16;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic logic [CNT_W-1:0] popcount16(
    input logic [LIST_W-1:0] v
  );
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LIST_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/reglist_encoder_priority_enc16.sv
// 16-to-4 priority encoder, lowest-first (dir=1) or highest-first.
// An empty mask encodes to index 0.
module priority_enc16
  import reglist_encoder_pkg::*;
(
  input  logic [LIST_W-1:0] mask,
  input  logic              dir,
  output logic [IDX_W-1:0]  index
);

  always_comb begin
    index = '0;
    if (dir) begin
      // scan downward so the lowest set bit wins
      for (int i = LIST_W - 1; i >= 0; i--) begin
        if (mask[i]) index = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < LIST_W; i++) begin
        if (mask[i]) index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reglist_encoder.sv
// Sequential register-list encoder for load/store multiple.
// Emits set register numbers one per accepted next.
module reglist_encoder
  import reglist_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LIST_W-1:0] list,
  input  logic              up,
  input  logic              next,
  output logic              valid,
  output logic [IDX_W-1:0]  R,
  output logic              last,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  remaining,
  output logic              busy,
  output logic              done
);

  state_t             state, state_n;
  logic [LIST_W-1:0]  mask, mask_n;
  logic               dir, dir_n;
  logic [CNT_W-1:0]   count_n, rem_n;
  logic [CNT_W-1:0]   pc;

  priority_enc16 u_enc (
    .mask  (mask),
    .dir   (dir),
    .index (R)
  );

  assign pc    = popcount16(list);
  assign valid = (state == ISSUE);
  assign last  = valid && (remaining == CNT_W'(1));
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mask      <= '0;
      dir       <= 1'b0;
      count     <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      mask      <= mask_n;
      dir       <= dir_n;
      count     <= count_n;
      remaining <= rem_n;
    end
  end

  always_comb begin
    state_n = state;
    mask_n  = mask;
    dir_n   = dir;
    count_n = count;
    rem_n   = remaining;
    unique case (state)
      IDLE: begin
        if (start) begin
          mask_n  = list;
          dir_n   = up;
          count_n = pc;
          rem_n   = pc;
          state_n = (list != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (next) begin
          mask_n = mask & ~(LIST_W'(1) << R);
          rem_n  = remaining - CNT_W'(1);
          if (last) state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reglist_encoder.sv
// Directed bench for reglist_encoder: vector table plus
// hand-written toggle, ignored-start and mid-sequence reset cases.
module tb_reglist_encoder;

  logic        clk = 1'b0;
  logic        reset, start, up, next;
  logic [15:0] list;
  logic        valid, last, busy, done;
  logic [3:0]  R;
  logic [4:0]  count, remaining;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] list;
    logic        up;
    int          n;
    logic [63:0] seq;
  } vec_t;

  vec_t vecs [7];

  reglist_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .list      (list),
    .up        (up),
    .next      (next),
    .valid     (valid),
    .R         (R),
    .last      (last),
    .count     (count),
    .remaining (remaining),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run_seq(input vec_t v, input bit poke);
    @(negedge clk);
    list  = v.list;
    up    = v.up;
    start = 1'b1;
    next  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    list  = 16'h0;
    up    = ~v.up;
    if (v.n == 0) begin
      chk("empty_valid", int'(valid), 0);
      chk("empty_done", int'(done), 1);
      chk("empty_count", int'(count), 0);
      chk("empty_busy", int'(busy), 1);
      @(negedge clk);
      chk("empty_busy_off", int'(busy), 0);
      chk("empty_done_off", int'(done), 0);
      chk("empty_valid_off", int'(valid), 0);
    end else begin
      for (int k = 0; k < v.n; k++) begin
        chk("seq_valid", int'(valid), 1);
        chk("seq_R", int'(R), int'(v.seq[4*k +: 4]));
        chk("seq_rem", int'(remaining), v.n - k);
        chk("seq_last", int'(last), int'(k == v.n - 1));
        chk("seq_count", int'(count), v.n);
        chk("seq_done", int'(done), 0);
        if (poke && k == 1) begin
          start = 1'b1;
          list  = 16'h0001;
          up    = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
      end
      chk("end_done", int'(done), 1);
      chk("end_valid", int'(valid), 0);
      chk("end_busy", int'(busy), 1);
      @(negedge clk);
      chk("end_busy_off", int'(busy), 0);
      chk("end_done_off", int'(done), 0);
      chk("end_count_hold", int'(count), v.n);
    end
    next = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h8421, 1'b1, 4, 64'h0000_0000_0000_FA50};
    vecs[1] = '{16'h8421, 1'b0, 4, 64'h0000_0000_0000_05AF};
    vecs[2] = '{16'h0000, 1'b1, 0, 64'h0};
    vecs[3] = '{16'h0003, 1'b1, 2, 64'h0000_0000_0000_0010};
    vecs[4] = '{16'h8000, 1'b0, 1, 64'h0000_0000_0000_000F};
    vecs[5] = '{16'hA000, 1'b1, 2, 64'h0000_0000_0000_00FD};
    vecs[6] = '{16'h1248, 1'b0, 4, 64'h0000_0000_0000_369C};

    reset = 1'b1;
    start = 1'b0;
    up    = 1'b0;
    next  = 1'b0;
    list  = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_rem", int'(remaining), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;

    // next in IDLE must not start anything
    next = 1'b1;
    @(negedge clk);
    chk("idle_next_busy", int'(busy), 0);
    next = 1'b0;

    for (int i = 0; i < 7; i++) run_seq(vecs[i], 1'b0);

    // start while busy is ignored
    run_seq(vecs[0], 1'b1);

    // full list with next toggled every other cycle
    @(negedge clk);
    list  = 16'hFFFF;
    up    = 1'b1;
    start = 1'b1;
    next  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("full_count", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("full_R", int'(R), i);
      chk("full_rem", int'(remaining), 16 - i);
      chk("full_last", int'(last), int'(i == 15));
      @(negedge clk);
      chk("full_R_hold", int'(R), i);
      chk("full_valid", int'(valid), 1);
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
    end
    chk("full_done", int'(done), 1);
    @(negedge clk);
    chk("full_busy_off", int'(busy), 0);

    // reset in the middle of a sequence
    @(negedge clk);
    list  = 16'h00F0;
    up    = 1'b1;
    start = 1'b1;
    next  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("mid_R0", int'(R), 4);
    chk("mid_count", int'(count), 4);
    next = 1'b1;
    @(negedge clk);
    chk("mid_R1", int'(R), 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    next  = 1'b0;
    chk("mrst_valid", int'(valid), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_R", int'(R), 0);
    chk("mrst_count", int'(count), 0);
    chk("mrst_rem", int'(remaining), 0);
    chk("mrst_done", int'(done), 0);
    @(negedge clk);
    chk("mrst_done2", int'(done), 0);
    chk("mrst_busy2", int'(busy), 0);

    // fresh start after the abandoned sequence
    run_seq(vecs[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
